// File: rtl/fm_audio_pkg.sv
// Shared audio constants and the I2S transmitter state type.
package fm_audio_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned I2S_SLOTS  = 2;
  localparam int unsigned FRAME_BITS = I2S_SLOTS * DATA_W_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } i2s_state_e;

  // Counter width that stays legal when the terminal count is 1.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/fm_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only when a pop frees a slot that cycle.
module fm_sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_c,
  output logic             full_c,
  output logic             empty_c,
  output logic [LVL_W-1:0] level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             do_push;
  logic             do_pop;

  assign full_c  = (level_q == LVL_W'(DEPTH));
  assign empty_c = (level_q == '0);
  assign do_pop  = pop_i && !empty_c;
  assign do_push = push_i && (!full_c || do_pop);
  assign dout_c  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (do_pop && !do_push) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/fm_i2s_tx.sv
// Philips I2S master transmitter: FIFO-buffered mono samples duplicated to both slots.
// Optional build macro FM_I2S_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module fm_i2s_tx
  import fm_audio_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned BCLK_HALF  = 32,
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  input  logic              enable,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              overflow,
  output logic              underrun,
  output logic              i2s_bclk,
  output logic              i2s_lrclk,
  output logic              i2s_sdata
`ifdef FM_I2S_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       underrun_cnt
`endif
);

  localparam int unsigned FRAME_W = I2S_SLOTS * DATA_W;
  localparam int unsigned BIT_W   = $clog2(FRAME_W);
  localparam int unsigned IDX_W   = $clog2(DATA_W);
  localparam int unsigned DIV_W   = clog2_min1(BCLK_HALF);

  i2s_state_e        state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              bclk_q, bclk_d;
  logic              lrclk_q, lrclk_d;
  logic              sdata_q, sdata_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              last_lsb_q, last_lsb_d;
  logic              underrun_q, underrun_d;
  logic              overflow_q, overflow_d;
  logic              frame_start_c;
  logic              shift_c;
  logic              fifo_pop_c;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LVL_W-1:0]  fifo_level_w;

  fm_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (sample_valid),
    .din_i   (sample),
    .pop_i   (fifo_pop_c),
    .dout_c  (fifo_dout),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .level_o (fifo_level_w)
  );

  // Slot bit k of the frame: bit 0 carries the previous word's LSB (one-bclk I2S delay).
  function automatic logic slot_bit(input logic [BIT_W-1:0] k, input logic [DATA_W-1:0] word,
                                    input logic lsb);
    logic [BIT_W-1:0] j;
    logic             b;
    j = (k > BIT_W'(DATA_W)) ? k - BIT_W'(DATA_W) : k;
    b = (k == '0) ? lsb : word[IDX_W'(BIT_W'(DATA_W) - j)];
    return b;
  endfunction

  always_comb begin
    state_d       = state_q;
    div_cnt_d     = div_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    bclk_d        = bclk_q;
    lrclk_d       = lrclk_q;
    sdata_d       = sdata_q;
    hold_d        = hold_q;
    last_lsb_d    = last_lsb_q;
    underrun_d    = 1'b0;
    fifo_pop_c    = 1'b0;
    frame_start_c = 1'b0;
    shift_c       = 1'b0;
    overflow_d    = 1'b0;

    case (state_q)
      IDLE, PRIME: begin
        div_cnt_d = '0;
        bit_cnt_d = '0;
        bclk_d    = 1'b0;
        lrclk_d   = 1'b0;
        sdata_d   = 1'b0;
        if (state_q == IDLE) begin
          if (enable) state_d = PRIME;
        end else if (!enable) begin
          state_d = IDLE;
        end else if (fifo_level_w >= LVL_W'(FIFO_DEPTH / 2)) begin
          state_d       = RUN;
          last_lsb_d    = 1'b0;
          frame_start_c = 1'b1;
          shift_c       = 1'b1;
        end
      end
      RUN: begin
        if (div_cnt_q == DIV_W'(BCLK_HALF - 1)) begin
          div_cnt_d = '0;
          bclk_d    = !bclk_q;
          if (bclk_q) begin
            if (bit_cnt_q == BIT_W'(FRAME_W - 1)) begin
              bit_cnt_d = '0;
              if (enable) begin
                frame_start_c = 1'b1;
                last_lsb_d    = hold_q[0];
                shift_c       = 1'b1;
              end else begin
                state_d = IDLE;
                lrclk_d = 1'b0;
                sdata_d = 1'b0;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
              shift_c   = 1'b1;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame start reloads the hold word, or substitutes silence when starved.
    if (frame_start_c) begin
      if (fifo_empty) begin
        hold_d     = '0;
        underrun_d = 1'b1;
      end else begin
        fifo_pop_c = 1'b1;
        hold_d     = fifo_dout;
      end
    end

    if (shift_c) begin
      lrclk_d = (bit_cnt_d >= BIT_W'(DATA_W));
      sdata_d = slot_bit(bit_cnt_d, hold_d, last_lsb_d);
    end

    overflow_d = sample_valid && fifo_full && !fifo_pop_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      hold_q     <= '0;
      last_lsb_q <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      hold_q     <= hold_d;
      last_lsb_q <= last_lsb_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef FM_I2S_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt_q <= '0;
    end else if (underrun_d && (underrun_cnt_q != 16'hFFFF)) begin
      underrun_cnt_q <= underrun_cnt_q + 16'd1;
    end
  end

  assign underrun_cnt = underrun_cnt_q;
`endif

  assign fifo_level = fifo_level_w;
  assign overflow   = overflow_q;
  assign underrun   = underrun_q;
  assign i2s_bclk   = bclk_q;
  assign i2s_lrclk  = lrclk_q;
  assign i2s_sdata  = sdata_q;

endmodule
